// File: rtl/ecg_bit_window.sv
// ecg_bit_window: packs 64-bit substream words into an MSB-aligned
// 192-bit buffer and presents a 128-bit window to the ECG parser.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          clear all buffered bits and return to IDLE
//   in_data        next substream word, MSB first in stream order
//   in_valid       in_data is valid
//   in_last        in_data is the final word of the substream
//   in_ready       word accepted when in_valid & in_ready
//   win_data       top 128 bits of the buffer; bit 127 is the next bit
//   win_valid      window may be parsed this cycle
//   consume_en     parser consumes consume_bits this cycle
//   consume_bits   bits consumed, 1..128
//   fill_level     valid bits in the buffer, 0..192
//   bits_consumed  running total of consumed bits since reset/flush
//   err_overrun    sticky, set on an illegal consume
module ecg_bit_window #(
    parameter int IN_W  = 64,
    parameter int WIN_W = 128,
    parameter int BUF_W = 192
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIN_W-1:0] win_data,
    output logic             win_valid,
    input  logic             consume_en,
    input  logic [7:0]       consume_bits,
    output logic [7:0]       fill_level,
    output logic [31:0]      bits_consumed,
    output logic             err_overrun
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [8:0] WIN9 = 9'(WIN_W);
    localparam logic [8:0] IN9  = 9'(IN_W);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [8:0]       fill_q, fill_d;
    logic [1:0]       state_q, state_d;
    logic [31:0]      bits_q, bits_d;
    logic             err_q, err_d;

    logic             accept;
    logic             legal;
    logic [8:0]       cb9;
    logic [8:0]       cmax;
    logic [8:0]       c;
    logic [BUF_W-1:0] rem;
    logic [BUF_W-1:0] ins;

    // in_ready/win_valid depend only on registered state, so the
    // parser's consume request never reaches in_ready combinationally.
    assign in_ready  = (state_q != S_DRAIN) && (fill_q <= WIN9);
    assign win_valid = (fill_q >= WIN9) ||
                       ((state_q == S_DRAIN) && (fill_q != 9'd0));

    always_comb begin
        accept = in_valid && in_ready && !flush;
        cb9    = {1'b0, consume_bits};
        cmax   = (fill_q < WIN9) ? fill_q : WIN9;
        legal  = consume_en && win_valid &&
                 (cb9 != 9'd0) && (cb9 <= cmax);
        c      = legal ? cb9 : 9'd0;

        // Left shift zero-fills from the bottom, so bits below the new
        // fill stay zero and the word can simply be OR-ed in.
        rem = buf_q << c;
        ins = '0;
        if (accept) begin
            ins = {in_data, {WIN_W{1'b0}}} >> (fill_q - c);
        end

        buf_d  = rem | ins;
        fill_d = fill_q - c + (accept ? IN9 : 9'd0);
        bits_d = bits_q + {23'd0, c};
        err_d  = err_q || (consume_en && !legal);

        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = in_last ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end else if (fill_d >= WIN9) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                end else if (fill_d < WIN9) begin
                    state_d = S_FILL;
                end
            end
            S_DRAIN: begin
                if (fill_d == 9'd0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            buf_d   = '0;
            fill_d  = 9'd0;
            bits_d  = 32'd0;
            err_d   = 1'b0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q   <= '0;
            fill_q  <= 9'd0;
            state_q <= S_IDLE;
            bits_q  <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            state_q <= state_d;
            bits_q  <= bits_d;
            err_q   <= err_d;
        end
    end

    assign win_data      = buf_q[BUF_W-1 -: WIN_W];
    assign fill_level    = fill_q[8] ? 8'hFF : fill_q[7:0];
    assign bits_consumed = bits_q;
    assign err_overrun   = err_q;

endmodule

// File: tb/tb_ecg_bit_window.sv
// tb_ecg_bit_window: directed scenarios for ecg_bit_window with
// hand-computed expected fill, window and status values.
module tb_ecg_bit_window;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    localparam logic [63:0] WA = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] WB = 64'h0000_0000_0000_0000;
    localparam logic [63:0] WC = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WD = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WE = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] WF = 64'hDEAD_BEEF_CAFE_F00D;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic [63:0]  in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] win_data;
    logic         win_valid;
    logic         consume_en;
    logic [7:0]   consume_bits;
    logic [7:0]   fill_level;
    logic [31:0]  bits_consumed;
    logic         err_overrun;

    int checks = 0;
    int failures = 0;

    ecg_bit_window dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .win_data     (win_data),
        .win_valid    (win_valid),
        .consume_en   (consume_en),
        .consume_bits (consume_bits),
        .fill_level   (fill_level),
        .bits_consumed(bits_consumed),
        .err_overrun  (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic consume(input logic [7:0] n);
        consume_en   = 1'b1;
        consume_bits = n;
        tick();
        consume_en   = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (fill_level !== 8'd0) begin
            failures++;
            $display("FAIL reset_fill: got %0d want 0", fill_level);
        end
        checks++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs: got rdy=%b wv=%b want 1 0",
                     in_ready, win_valid);
        end
        checks++;
        if (bits_consumed !== 32'd0 || err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_cnt: got bc=%0d err=%b want 0 0",
                     bits_consumed, err_overrun);
        end
        checks++;
        if (dut.state_q !== S_IDLE || win_data !== 128'd0) begin
            failures++;
            $display("FAIL reset_state: got st=%0d win=%h want 0 0",
                     dut.state_q, win_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_fill();
        push(WA, 1'b0);
        checks++;
        if (fill_level !== 8'd64 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL fill_a: got fill=%0d wv=%b want 64 0",
                     fill_level, win_valid);
        end
        push(WB, 1'b0);
        checks++;
        if (fill_level !== 8'd128 || win_valid !== 1'b1 ||
            in_ready !== 1'b1) begin
            failures++;
            $display("FAIL fill_b: got fill=%0d wv=%b rdy=%b want 128 1 1",
                     fill_level, win_valid, in_ready);
        end
        push(WC, 1'b0);
        checks++;
        if (fill_level !== 8'd192 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_c: got fill=%0d rdy=%b want 192 0",
                     fill_level, in_ready);
        end
        checks++;
        if (win_data !== {WA, WB}) begin
            failures++;
            $display("FAIL fill_win: got %h want %h", win_data, {WA, WB});
        end
        checks++;
        if (dut.state_q !== S_RUN) begin
            failures++;
            $display("FAIL fill_state: got %0d want %0d",
                     dut.state_q, S_RUN);
        end
    endtask

    task automatic test_consume3();
        consume(8'd3);
        checks++;
        if (win_data !== {64'hFFFF_FFFF_FFFF_FFF8,
                          64'h0000_0000_0000_0005}) begin
            failures++;
            $display("FAIL cons3_win: got %h", win_data);
        end
        checks++;
        if (fill_level !== 8'd189 || bits_consumed !== 32'd3) begin
            failures++;
            $display("FAIL cons3_fill: got fill=%0d bc=%0d want 189 3",
                     fill_level, bits_consumed);
        end
    endtask

    task automatic test_steady();
        logic [127:0] exp;
        consume(8'd61);
        checks++;
        if (fill_level !== 8'd128 || win_data !== {WB, WC} ||
            dut.state_q !== S_RUN) begin
            failures++;
            $display("FAIL steady_pre: got fill=%0d win=%h st=%0d",
                     fill_level, win_data, dut.state_q);
        end
        consume_en   = 1'b1;
        consume_bits = 8'd79;
        in_valid     = 1'b1;
        in_data      = WD;
        tick();
        consume_en = 1'b0;
        in_valid   = 1'b0;
        exp = {WC[48:0], WD, 15'd0};
        checks++;
        if (fill_level !== 8'd113 || dut.state_q !== S_FILL) begin
            failures++;
            $display("FAIL steady_fill: got fill=%0d st=%0d want 113 1",
                     fill_level, dut.state_q);
        end
        checks++;
        if (win_data !== exp) begin
            failures++;
            $display("FAIL steady_win: got %h want %h", win_data, exp);
        end
        checks++;
        if (bits_consumed !== 32'd143) begin
            failures++;
            $display("FAIL steady_bc: got %0d want 143", bits_consumed);
        end
        push(WE, 1'b0);
        checks++;
        if (fill_level !== 8'd177 || dut.state_q !== S_RUN) begin
            failures++;
            $display("FAIL steady_back: got fill=%0d st=%0d want 177 2",
                     fill_level, dut.state_q);
        end
    endtask

    task automatic test_drain();
        consume(8'd77);
        checks++;
        if (fill_level !== 8'd100) begin
            failures++;
            $display("FAIL drain_pre: got %0d want 100", fill_level);
        end
        push(WF, 1'b1);
        checks++;
        if (fill_level !== 8'd164 || dut.state_q !== S_DRAIN ||
            in_ready !== 1'b0 || win_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_enter: got fill=%0d st=%0d rdy=%b wv=%b",
                     fill_level, dut.state_q, in_ready, win_valid);
        end
        // a word offered during DRAIN must be ignored
        in_valid = 1'b1;
        in_data  = WA;
        consume(8'd60);
        in_valid = 1'b0;
        checks++;
        if (fill_level !== 8'd104) begin
            failures++;
            $display("FAIL drain_60a: got %0d want 104", fill_level);
        end
        consume(8'd60);
        checks++;
        if (fill_level !== 8'd44 || win_valid !== 1'b1) begin
            failures++;
            $display("FAIL drain_60b: got fill=%0d wv=%b want 44 1",
                     fill_level, win_valid);
        end
        checks++;
        if (win_data[127:84] !== WF[43:0] ||
            win_data[83:0] !== 84'd0) begin
            failures++;
            $display("FAIL drain_pad: got %h want %h", win_data,
                     {WF[43:0], 84'd0});
        end
        consume(8'd44);
        checks++;
        if (fill_level !== 8'd0 || dut.state_q !== S_IDLE ||
            in_ready !== 1'b1 || win_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_end: got fill=%0d st=%0d rdy=%b wv=%b",
                     fill_level, dut.state_q, in_ready, win_valid);
        end
        checks++;
        if (bits_consumed !== 32'd384 || err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL drain_bc: got bc=%0d err=%b want 384 0",
                     bits_consumed, err_overrun);
        end
    endtask

    task automatic test_illegal();
        do_flush();
        consume(8'd8);
        checks++;
        if (err_overrun !== 1'b1 || fill_level !== 8'd0) begin
            failures++;
            $display("FAIL ill_nowin: got err=%b fill=%0d want 1 0",
                     err_overrun, fill_level);
        end
        do_flush();
        checks++;
        if (err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL ill_flushclr: got %b want 0", err_overrun);
        end
        push(WC, 1'b0);
        push(WD, 1'b0);
        consume(8'd0);
        checks++;
        if (err_overrun !== 1'b1 || fill_level !== 8'd128) begin
            failures++;
            $display("FAIL ill_zero: got err=%b fill=%0d want 1 128",
                     err_overrun, fill_level);
        end
        do_flush();
        push(WC, 1'b0);
        push(WD, 1'b0);
        // illegal size with a word accepted in the same cycle
        in_valid = 1'b1;
        in_data  = WE;
        consume(8'd150);
        in_valid = 1'b0;
        checks++;
        if (err_overrun !== 1'b1 || fill_level !== 8'd192 ||
            bits_consumed !== 32'd0) begin
            failures++;
            $display("FAIL ill_150: got err=%b fill=%0d bc=%0d want 1 192 0",
                     err_overrun, fill_level, bits_consumed);
        end
        consume(8'd8);
        checks++;
        if (err_overrun !== 1'b1 || fill_level !== 8'd184 ||
            bits_consumed !== 32'd8) begin
            failures++;
            $display("FAIL ill_sticky: got err=%b fill=%0d bc=%0d want 1 184 8",
                     err_overrun, fill_level, bits_consumed);
        end
    endtask

    task automatic test_flush();
        do_flush();
        push(WA, 1'b0);
        push(WB, 1'b0);
        push(WC, 1'b0);
        consume(8'd64);
        checks++;
        if (fill_level !== 8'd128 || bits_consumed !== 32'd64 ||
            dut.state_q !== S_RUN) begin
            failures++;
            $display("FAIL flush_pre: got fill=%0d bc=%0d st=%0d",
                     fill_level, bits_consumed, dut.state_q);
        end
        flush        = 1'b1;
        in_valid     = 1'b1;
        in_data      = WD;
        consume_en   = 1'b1;
        consume_bits = 8'd8;
        tick();
        flush      = 1'b0;
        in_valid   = 1'b0;
        consume_en = 1'b0;
        checks++;
        if (fill_level !== 8'd0 || dut.state_q !== S_IDLE ||
            bits_consumed !== 32'd0) begin
            failures++;
            $display("FAIL flush_mid: got fill=%0d st=%0d bc=%0d want 0 0 0",
                     fill_level, dut.state_q, bits_consumed);
        end
        checks++;
        if (in_ready !== 1'b1 || win_valid !== 1'b0 ||
            win_data !== 128'd0 || err_overrun !== 1'b0) begin
            failures++;
            $display("FAIL flush_out: got rdy=%b wv=%b win=%h err=%b",
                     in_ready, win_valid, win_data, err_overrun);
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        in_data      = 64'd0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        consume_en   = 1'b0;
        consume_bits = 8'd0;
        tick();
        test_reset();
        test_fill();
        test_consume3();
        test_steady();
        test_drain();
        test_illegal();
        test_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
